// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad key FIFO receive block.
//   key_code_t   4-bit key value from the scan driver
//   int_state_t  interrupt FSM states (IDLE, REQ, SERV)
//   KEY_EMPTY_RD value returned by the data port when no key is queued
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } int_state_t;

  localparam logic [7:0] KEY_EMPTY_RD  = 8'hFF;
  localparam logic [7:0] DATA_PORT_DEF = 8'h96;
  localparam logic [7:0] STAT_PORT_DEF = 8'h97;

endpackage

// File: rtl/keypad_key_fifo_if_if.sv
// keypad_key_fifo_if_if: key-event and MCU IN-port signal bundle.
//   key_evt, key_code          scan driver -> block
//   port_id, rd_strb, int_ack  MCU -> block
//   in_data, intr, ovf         block -> MCU
// modport slave is the block side, modport master the driver/MCU side.
interface keypad_key_fifo_if_if;
  import keypad_pkg::*;

  logic      key_evt;
  key_code_t key_code;
  logic [7:0] port_id;
  logic      rd_strb;
  logic      int_ack;
  logic [7:0] in_data;
  logic      intr;
  logic      ovf;

  modport master (
    output key_evt, key_code, port_id, rd_strb, int_ack,
    input  in_data, intr, ovf
  );

  modport slave (
    input  key_evt, key_code, port_id, rd_strb, int_ack,
    output in_data, intr, ovf
  );

endinterface

// File: rtl/key_fifo.sv
// key_fifo: small key-code FIFO with extra-bit pointers.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_din    write request and key code
//   i_pop            read request (ignored when empty)
//   o_dout           oldest entry
//   o_full, o_empty  occupancy flags
//   o_count          number of queued entries
//   o_ovf_evt        push into a full FIFO without a pop this cycle
// Macro KPD_OVERWRITE_EN: when defined, a push into a full FIFO replaces the oldest
// entry; otherwise that push is dropped.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  key_code_t i_din,
  output key_code_t o_dout,
  output logic      o_full,
  output logic      o_empty,
  output logic [4:0] o_count,
  output logic      o_ovf_evt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  key_code_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW-1:0] w_wr_ptr_d, w_rd_ptr_d, w_count;
  logic          w_pop, w_wr_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_count = 5'(w_count);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_pop      = i_pop && !o_empty;
    w_wr_en    = 1'b0;
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    o_ovf_evt  = 1'b0;
    if (w_pop) begin
      w_rd_ptr_d = r_rd_ptr + PW'(1);
    end
    if (i_push) begin
      // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
      if (!o_full || w_pop) begin
        w_wr_en    = 1'b1;
        w_wr_ptr_d = r_wr_ptr + PW'(1);
      end else begin
        o_ovf_evt = 1'b1;
`ifdef KPD_OVERWRITE_EN
        // Drop the oldest key so the newest DEPTH keys survive.
        w_wr_en    = 1'b1;
        w_wr_ptr_d = r_wr_ptr + PW'(1);
        w_rd_ptr_d = r_rd_ptr + PW'(1);
`else
        w_wr_en    = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/keypad_key_fifo_if.sv
// keypad_key_fifo_if: keypad receive side. Captures key-down edges into a FIFO, raises an
// MCU interrupt and serves key/status bytes on the MCU IN-port bus.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   io_bus (slave)  key_evt/key_code in, port_id/rd_strb/int_ack in, in_data/intr/ovf out
//   DATA_PORT read: {4'h0, oldest key} or 8'hFF when empty; RD_STRB pops.
//   STAT_PORT read: {ovf, 2'b00, empty, count[3:0]}; RD_STRB clears ovf.
// Macro KPD_OVERWRITE_EN (in key_fifo): overwrite oldest key on overflow instead of dropping.
module keypad_key_fifo_if
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  DATA_PORT = DATA_PORT_DEF,
  parameter logic [7:0]  STAT_PORT = STAT_PORT_DEF
) (
  input logic               i_clk,
  input logic               i_rst_n,
  keypad_key_fifo_if_if.slave io_bus
);

  logic       r_key_prev, r_intr, r_ovf;
  int_state_t r_state, w_state_d;
  logic       w_push, w_data_sel, w_stat_sel, w_pop_req, w_pop_done, w_stat_rd;
  logic       w_full, w_empty, w_ovf_evt;
  key_code_t  w_head;
  logic [4:0] w_count;
  logic [7:0] w_in_data;

  assign w_push     = io_bus.key_evt && !r_key_prev;
  assign w_data_sel = (io_bus.port_id == DATA_PORT);
  assign w_stat_sel = (io_bus.port_id == STAT_PORT);
  assign w_pop_req  = io_bus.rd_strb && w_data_sel;
  assign w_pop_done = w_pop_req && !w_empty;
  assign w_stat_rd  = io_bus.rd_strb && w_stat_sel;

  key_fifo #(
    .DEPTH (DEPTH)
  ) u_key_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop_req),
    .i_din     (io_bus.key_code),
    .o_dout    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_ovf_evt (w_ovf_evt)
  );

  always_comb begin
    w_in_data = 8'h00;
    if (w_data_sel) begin
      w_in_data = w_empty ? KEY_EMPTY_RD : {4'h0, w_head};
    end else if (w_stat_sel) begin
      w_in_data = {r_ovf, 2'b00, w_empty, w_count[3:0]};
    end
  end

  assign io_bus.in_data = w_in_data;
  assign io_bus.intr    = r_intr;
  assign io_bus.ovf     = r_ovf;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (!w_empty)        w_state_d = REQ;
      REQ:     if (io_bus.int_ack)  w_state_d = SERV;
      SERV:    if (w_pop_done)      w_state_d = IDLE;
      default:                      w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key_prev <= 1'b0;
      r_state    <= IDLE;
      r_intr     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_key_prev <= io_bus.key_evt;
      r_state    <= w_state_d;
      // INTR lags the REQ state by one register stage; an ack drops it at once.
      r_intr     <= (r_state == REQ) && !io_bus.int_ack;
      // A same-cycle overflow beats the status-read clear.
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (w_stat_rd) begin
        r_ovf <= 1'b0;
      end
    end
  end

  logic w_unused;
  assign w_unused = w_full;

endmodule
